// File: rtl/message_arbiter_pkg.sv
// Shared encodings and constants for the message-atomic rs232_tx arbiter.
// Optional timeout release is built when MESSAGE_ARBITER_TIMEOUT_EN is defined.
package message_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccept = 2'd1,
        StSend   = 2'd2
    } state_e;

    typedef enum logic {
        GrantIn1 = 1'b0,
        GrantIn2 = 1'b1
    } grant_e;

    localparam logic [7:0] EomDefault = 8'h0A;
    localparam int unsigned TimerWidth = 16;

    function automatic grant_e other_grant(input grant_e g);
        return (g == GrantIn1) ? GrantIn2 : GrantIn1;
    endfunction

endpackage

// File: rtl/message_arbiter_timer.sv
// Stall timer for a locked producer; expired_o flags that the current stalled
// cycle is the Limit-th one. Only instantiated under MESSAGE_ARBITER_TIMEOUT_EN.
module message_arbiter_timer
    import message_arbiter_pkg::*;
#(
    parameter int unsigned Limit = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);

    localparam logic [TimerWidth-1:0] LastCount = TimerWidth'(Limit - 1);

    logic [TimerWidth-1:0] count_q, count_d;

    assign expired_o = (count_q == LastCount);

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (en_i && !expired_o) begin
            count_d = count_q + TimerWidth'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/message_arbiter.sv
// Round-robin, message-atomic arbiter merging two 32-bit rs232_tx streams.
// Define MESSAGE_ARBITER_TIMEOUT_EN to build the stalled-lock timeout release.
module message_arbiter
    import message_arbiter_pkg::*;
#(
    parameter logic [7:0]  EOM     = EomDefault,
    parameter int unsigned TIMEOUT = 1000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        exception,
    input  logic [31:0] input_in1,
    input  logic        input_in1_stb,
    output logic        input_in1_ack,
    input  logic [31:0] input_in2,
    input  logic        input_in2_stb,
    output logic        input_in2_ack,
    output logic [31:0] output_out,
    output logic        output_out_stb,
    input  logic        output_out_ack
);

    if ((TIMEOUT == 0) || (TIMEOUT > 65535)) begin : g_bad_timeout
        $error("message_arbiter: TIMEOUT must be in 1..65535");
    end

    state_e      state_q, state_d;
    grant_e      grant_q, grant_d;
    grant_e      last_grant_q, last_grant_d;
    logic [31:0] out_q, out_d;
    logic        granted_stb;
    logic [31:0] granted_data;
    logic        timeout_hit;

    assign granted_stb  = (grant_q == GrantIn1) ? input_in1_stb : input_in2_stb;
    assign granted_data = (grant_q == GrantIn1) ? input_in1 : input_in2;

`ifdef MESSAGE_ARBITER_TIMEOUT_EN
    logic stall;
    logic timer_expired;
    logic exception_q;

    assign stall = (state_q == StAccept) && !granted_stb;

    // Held clear outside ACCEPT so every entry to ACCEPT starts from zero.
    message_arbiter_timer #(
        .Limit(TIMEOUT)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (state_q != StAccept),
        .en_i     (stall),
        .expired_o(timer_expired)
    );

    assign timeout_hit = stall && timer_expired;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exception_q <= 1'b0;
        end else begin
            exception_q <= exception_q | timeout_hit;
        end
    end

    assign exception = exception_q;
`else
    assign timeout_hit = 1'b0;
    assign exception   = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        out_d        = out_q;
        unique case (state_q)
            StIdle: begin
                if (input_in1_stb && input_in2_stb) begin
                    grant_d = other_grant(last_grant_q);
                    state_d = StAccept;
                end else if (input_in1_stb) begin
                    grant_d = GrantIn1;
                    state_d = StAccept;
                end else if (input_in2_stb) begin
                    grant_d = GrantIn2;
                    state_d = StAccept;
                end
            end
            StAccept: begin
                // A transfer on the expiry cycle takes priority over the timeout.
                if (granted_stb) begin
                    out_d   = granted_data;
                    state_d = StSend;
                end else if (timeout_hit) begin
                    last_grant_d = grant_q;
                    state_d      = StIdle;
                end
            end
            StSend: begin
                if (output_out_ack) begin
                    if (out_q[7:0] == EOM) begin
                        last_grant_d = grant_q;
                        state_d      = StIdle;
                    end else begin
                        state_d = StAccept;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            grant_q      <= GrantIn1;
            last_grant_q <= GrantIn2;
            out_q        <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            out_q        <= out_d;
        end
    end

    assign input_in1_ack  = (state_q == StAccept) && (grant_q == GrantIn1);
    assign input_in2_ack  = (state_q == StAccept) && (grant_q == GrantIn2);
    assign output_out_stb = (state_q == StSend);
    assign output_out     = out_q;

endmodule
